// File: rtl/hub75_rx_monitor.sv
// hub75_rx_monitor
//   Receive-side model of a HUB75 panel. Samples the HUB75 bus in the clk
//   domain, rebuilds the row shift chain, and on each latch streams the
//   latched row out as column words over a valid/ready write port. It also
//   times how long OE stays active (low) after each latch and keeps sticky
//   protocol-error flags.
//
// Ports
//   clk, rst_n             system clock, async active-low reset
//   i_enable               monitor enable (synchronisers always run)
//   O_CLK, STB, OE         HUB75 shift clock, latch strobe, output enable (low)
//   A..D                   row select, A = LSB
//   R1,G1,B1,R2,G2,B2      colour bits for the upper/lower halves
//   o_wr_valid/i_wr_ready  column word handshake
//   o_wr_addr              {row, col}
//   o_wr_data              {R1,G1,B1,R2,G2,B2} of that column
//   o_wr_last              high on column hpixel_p-1
//   o_oe_valid             1-cycle pulse: o_oe_row/o_oe_cycles valid
//   o_err_count            sticky: latch after a shift count other than hpixel_p
//   o_err_overrun          sticky: latch arrived while dumping, dropped
module hub75_rx_monitor #(
   parameter int hpixel_p       = 64,
   parameter int oe_cnt_width_p = 16,
   parameter int sync_stages_p  = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_enable,
   input  logic                               O_CLK,
   input  logic                               STB,
   input  logic                               OE,
   input  logic                               A,
   input  logic                               B,
   input  logic                               C,
   input  logic                               D,
   input  logic                               R1,
   input  logic                               G1,
   input  logic                               B1,
   input  logic                               R2,
   input  logic                               G2,
   input  logic                               B2,
   output logic                               o_wr_valid,
   input  logic                               i_wr_ready,
   output logic [4+$clog2(hpixel_p)-1:0]      o_wr_addr,
   output logic [5:0]                         o_wr_data,
   output logic                               o_wr_last,
   output logic                               o_oe_valid,
   output logic [3:0]                         o_oe_row,
   output logic [oe_cnt_width_p-1:0]          o_oe_cycles,
   output logic                               o_err_count,
   output logic                               o_err_overrun
);

   localparam int COL_W = $clog2(hpixel_p);
   localparam int CNT_W = $clog2(hpixel_p + 2);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(hpixel_p + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(hpixel_p);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(hpixel_p - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_DUMP = 1'b1;

   // Bus layout: [12] O_CLK, [11] STB, [10] OE, [9:6] row {D,C,B,A}, [5:0] colour
   logic [12:0]                     bus_raw;
   logic [sync_stages_p-1:0][12:0]  sync_q;
   logic [2:0]                      edge_q;   // last stage of {O_CLK,STB,OE}, one cycle older
   logic [12:0]                     s_bus;

   assign bus_raw = {O_CLK, STB, OE, D, C, B, A, R1, G1, B1, R2, G2, B2};
   assign s_bus   = sync_q[sync_stages_p-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         edge_q <= '0;
      end else begin
         sync_q <= {sync_q[sync_stages_p-2:0], bus_raw};
         edge_q <= s_bus[12:10];
      end
   end

   logic       clk_rise, stb_rise, oe_rise, s_oe;
   logic [3:0] s_row;
   logic [5:0] s_data;

   // Edges are qualified by enable so a disabled monitor ignores the bus.
   assign clk_rise = i_enable & s_bus[12] & ~edge_q[2];
   assign stb_rise = i_enable & s_bus[11] & ~edge_q[1];
   assign oe_rise  = i_enable & s_bus[10] & ~edge_q[0];
   assign s_oe     = s_bus[10];
   assign s_row    = s_bus[9:6];
   assign s_data   = s_bus[5:0];

   logic [hpixel_p-1:0][5:0]   shift_q, shift_nxt, latch_q;
   logic [CNT_W-1:0]           shift_cnt, cnt_nxt;
   logic [0:0]                 state;
   logic [COL_W-1:0]           col;
   logic [3:0]                 row_q;     // row being dumped
   logic [3:0]                 oe_row_q;  // row of the most recent STB, even if dropped
   logic [oe_cnt_width_p-1:0]  oe_cnt;

   // Shift is resolved before the latch so a same-cycle O_CLK/STB pair
   // latches the new column and checks the incremented count.
   always_comb begin
      shift_nxt = shift_q;
      cnt_nxt   = shift_cnt;
      if (clk_rise) begin
         shift_nxt = {shift_q[hpixel_p-2:0], s_data};
         if (shift_cnt != CNT_SAT)
            cnt_nxt = shift_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q       <= '0;
         latch_q       <= '0;
         shift_cnt     <= '0;
         state         <= ST_IDLE;
         col           <= '0;
         row_q         <= '0;
         oe_row_q      <= '0;
         oe_cnt        <= '0;
         o_oe_valid    <= 1'b0;
         o_oe_row      <= '0;
         o_oe_cycles   <= '0;
         o_err_count   <= 1'b0;
         o_err_overrun <= 1'b0;
      end else begin
         shift_q    <= shift_nxt;
         o_oe_valid <= 1'b0;
         if (!i_enable) begin
            shift_cnt <= '0;
            oe_cnt    <= '0;
            col       <= '0;
            state     <= ST_IDLE;
         end else begin
            shift_cnt <= stb_rise ? '0 : cnt_nxt;

            if (stb_rise) begin
               oe_row_q <= s_row;
               if (cnt_nxt != CNT_FULL)
                  o_err_count <= 1'b1;
               if (state == ST_IDLE) begin
                  latch_q <= shift_nxt;
                  row_q   <= s_row;
                  col     <= '0;
                  state   <= ST_DUMP;
               end else begin
                  o_err_overrun <= 1'b1;
               end
            end

            if (state == ST_DUMP && i_wr_ready) begin
               if (col == COL_LAST) begin
                  col   <= '0;
                  state <= ST_IDLE;
               end else begin
                  col <= col + COL_W'(1);
               end
            end

            if (oe_rise && oe_cnt != '0) begin
               o_oe_valid  <= 1'b1;
               o_oe_cycles <= oe_cnt;
               o_oe_row    <= oe_row_q;
            end

            if (stb_rise || oe_rise)
               oe_cnt <= '0;
            else if (!s_oe && oe_cnt != '1)
               oe_cnt <= oe_cnt + oe_cnt_width_p'(1);
         end
      end
   end

   assign o_wr_valid = (state == ST_DUMP);
   assign o_wr_addr  = {row_q, col};
   assign o_wr_data  = latch_q[col];
   assign o_wr_last  = o_wr_valid && (col == COL_LAST);

endmodule

// File: tb/tb_hub75_rx_monitor.sv
module tb_hub75_rx_monitor;
   localparam int HP = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic i_enable = 1'b0;
   logic O_CLK = 1'b0, STB = 1'b0, OE = 1'b1;
   logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
   logic R1 = 1'b0, G1 = 1'b0, B1 = 1'b0, R2 = 1'b0, G2 = 1'b0, B2 = 1'b0;
   logic man_rdy = 1'b1, rnd_rdy = 1'b1, rand_ready = 1'b0;
   logic i_wr_ready;
   assign i_wr_ready = rand_ready ? rnd_rdy : man_rdy;

   logic        o_wr_valid, o_wr_last, o_oe_valid, o_err_count, o_err_overrun;
   logic [9:0]  o_wr_addr;
   logic [5:0]  o_wr_data;
   logic [3:0]  o_oe_row;
   logic [15:0] o_oe_cycles;

   logic        q8_wr_valid, q8_wr_last, q8_oe_valid, q8_err_count, q8_err_overrun;
   logic [9:0]  q8_wr_addr;
   logic [5:0]  q8_wr_data;
   logic [3:0]  q8_oe_row;
   logic [7:0]  q8_oe_cycles;

   hub75_rx_monitor #(.hpixel_p(HP), .oe_cnt_width_p(16), .sync_stages_p(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
      .O_CLK(O_CLK), .STB(STB), .OE(OE), .A(A), .B(B), .C(C), .D(D),
      .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
      .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_wr_last(o_wr_last), .o_oe_valid(o_oe_valid),
      .o_oe_row(o_oe_row), .o_oe_cycles(o_oe_cycles),
      .o_err_count(o_err_count), .o_err_overrun(o_err_overrun));

   // Narrow OE counter instance to see saturation; shares the bus.
   hub75_rx_monitor #(.hpixel_p(HP), .oe_cnt_width_p(8), .sync_stages_p(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
      .O_CLK(O_CLK), .STB(STB), .OE(OE), .A(A), .B(B), .C(C), .D(D),
      .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
      .o_wr_valid(q8_wr_valid), .i_wr_ready(1'b1), .o_wr_addr(q8_wr_addr),
      .o_wr_data(q8_wr_data), .o_wr_last(q8_wr_last), .o_oe_valid(q8_oe_valid),
      .o_oe_row(q8_oe_row), .o_oe_cycles(q8_oe_cycles),
      .o_err_count(q8_err_count), .o_err_overrun(q8_err_overrun));

   always #5 clk = ~clk;

   always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

   // Word collector and OE pulse monitors, sampled on the falling edge.
   int got_mem [4096];
   int got_n = 0;
   int oe_pulses = 0, oe8_pulses = 0;
   int oe_cyc = 0, oe8_cyc = 0, oe_row = 0, oe8_row = 0;

   always @(negedge clk) begin
      if (rst_n && o_wr_valid && i_wr_ready && got_n < 4096) begin
         got_mem[got_n] <= int'({o_wr_addr, o_wr_data, o_wr_last});
         got_n <= got_n + 1;
      end
      if (o_oe_valid) begin
         oe_pulses <= oe_pulses + 1;
         oe_cyc    <= int'(o_oe_cycles);
         oe_row    <= int'(o_oe_row);
      end
      if (q8_oe_valid) begin
         oe8_pulses <= oe8_pulses + 1;
         oe8_cyc    <= int'(q8_oe_cycles);
         oe8_row    <= int'(q8_oe_row);
      end
   end

   int n_cmp = 0, n_err = 0;
   int rd_ptr = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Panel model: the chain as a plain array, newest pixel at index 0.
   logic [5:0] chain [HP];
   logic [5:0] lrow_data [HP];
   logic [3:0] lrow = '0;
   int         since = 0;
   bit         m_err = 1'b0;

   task automatic model_reset();
      for (int i = 0; i < HP; i++) chain[i] = '0;
      since = 0;
      m_err = 1'b0;
   endtask

   task automatic model_push(input logic [5:0] d);
      for (int i = HP - 1; i > 0; i--) chain[i] = chain[i-1];
      chain[0] = d;
      since++;
   endtask

   task automatic model_strobe(input bit accept, input logic [3:0] r);
      if (since != HP) m_err = 1'b1;
      since = 0;
      if (accept) begin
         for (int i = 0; i < HP; i++) lrow_data[i] = chain[i];
         lrow = r;
      end
   endtask

   function automatic int exp_word(input int c);
      return int'({lrow, 6'(c), lrow_data[c], (c == HP - 1)});
   endfunction

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse(input logic [5:0] d);
      O_CLK = 1'b0;
      {R1, G1, B1, R2, G2, B2} = d;
      step(2);
      O_CLK = 1'b1;
      model_push(d);
      step(2);
      O_CLK = 1'b0;
   endtask

   task automatic strobe(input logic [3:0] r);
      {D, C, B, A} = r;
      step(2);
      STB = 1'b1;
      step(2);
      STB = 1'b0;
      step(2);
   endtask

   task automatic wait_col(input int cl, output bit f);
      f = 1'b0;
      for (int t = 0; t < 400 && !f; t++) begin
         @(posedge clk); #1;
         if (o_wr_valid && int'(o_wr_addr[5:0]) == cl) f = 1'b1;
      end
   endtask

   task automatic check_dump(input string nm);
      int t = 0;
      int act;
      while (got_n - rd_ptr < HP && t < 3000) begin @(negedge clk); t++; end
      repeat (10) @(negedge clk);
      chk({nm, ".words"}, got_n - rd_ptr, HP);
      for (int c = 0; c < HP; c++) begin
         act = (rd_ptr + c < got_n) ? got_mem[rd_ptr + c] : -1;
         chk($sformatf("%s.col%0d", nm, c), act, exp_word(c));
      end
      rd_ptr = got_n;
   endtask

   typedef struct {
      int         np;
      logic [3:0] row;
      bit         seq;      // data = pulse index, else random
      bit         exp_err;  // o_err_count after this row
   } vec_t;

   vec_t vt [5];

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit f;
      int p0, p8;

      vt[0] = '{64, 4'd5,  1'b1, 1'b0};
      vt[1] = '{64, 4'd0,  1'b0, 1'b0};
      vt[2] = '{63, 4'd12, 1'b1, 1'b1};
      vt[3] = '{65, 4'd15, 1'b1, 1'b1};
      vt[4] = '{64, 4'd7,  1'b0, 1'b1};

      model_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst.valid",    o_wr_valid, 0);
      chk("rst.addr",     o_wr_addr, 0);
      chk("rst.data",     o_wr_data, 0);
      chk("rst.last",     o_wr_last, 0);
      chk("rst.oe_valid", o_oe_valid, 0);
      chk("rst.oe_row",   o_oe_row, 0);
      chk("rst.oe_cyc",   o_oe_cycles, 0);
      chk("rst.err_cnt",  o_err_count, 0);
      chk("rst.err_ovr",  o_err_overrun, 0);
      step(3);
      rst_n = 1'b1;
      step(6);
      i_enable = 1'b1;
      step(2);

      // Table-driven rows: pulse count, row, expected sticky count error.
      for (int v = 0; v < 5; v++) begin
         for (int n = 0; n < vt[v].np; n++)
            pulse(vt[v].seq ? 6'(n) : 6'($urandom));
         model_strobe(1'b1, vt[v].row);
         strobe(vt[v].row);
         check_dump($sformatf("vec%0d", v));
         chk($sformatf("vec%0d.err_cnt", v), o_err_count, int'(vt[v].exp_err));
         chk($sformatf("vec%0d.err_ovr", v), o_err_overrun, 0);
      end

      // Backpressure: ready low for 10 cycles while col 17 is presented.
      for (int n = 0; n < HP; n++) pulse(6'(n));
      model_strobe(1'b1, 4'd5);
      fork
         strobe(4'd5);
         begin
            wait_col(17, f);
            chk("bp.reach17", int'(f), 1);
            man_rdy = 1'b0;
            repeat (10) begin
               @(negedge clk);
               chk("bp.hold", int'({o_wr_valid, o_wr_addr, o_wr_data}),
                   int'({1'b1, 4'd5, 6'd17, lrow_data[17]}));
            end
            @(posedge clk); #1;
            man_rdy = 1'b1;
         end
      join
      check_dump("bp");

      // Overrun: second STB 20 cycles after the first, mid-dump.
      for (int n = 0; n < HP; n++) pulse(6'($urandom));
      model_strobe(1'b1, 4'd3);
      strobe(4'd3);
      step(14);
      model_strobe(1'b0, 4'd11);
      strobe(4'd11);
      check_dump("ovr");
      chk("ovr.flag", o_err_overrun, 1);

      // OE timing: row 9 latched, OE low for 300 cycles.
      for (int n = 0; n < HP; n++) pulse(6'($urandom));
      model_strobe(1'b1, 4'd9);
      strobe(4'd9);
      check_dump("oe");
      p0 = oe_pulses;
      p8 = oe8_pulses;
      OE = 1'b0;
      step(300);
      OE = 1'b1;
      step(10);
      chk("oe.pulses",  oe_pulses - p0, 1);
      chk("oe.cycles",  oe_cyc, 300);
      chk("oe.row",     oe_row, 9);
      chk("oe8.pulses", oe8_pulses - p8, 1);
      chk("oe8.cycles", oe8_cyc, 255);
      chk("oe8.row",    oe8_row, 9);

      // Disable mid-dump at col 30, then a clean row after re-enable.
      for (int n = 0; n < HP; n++) pulse(6'($urandom));
      model_strobe(1'b1, 4'd2);
      fork
         strobe(4'd2);
         begin
            wait_col(30, f);
            chk("en.reach30", int'(f), 1);
            i_enable = 1'b0;
            step(1);
            chk("en.valid_off", o_wr_valid, 0);
         end
      join
      step(5);
      rd_ptr = got_n;
      i_enable = 1'b1;
      step(2);
      for (int n = 0; n < HP; n++) pulse(6'($urandom));
      model_strobe(1'b1, 4'd6);
      strobe(4'd6);
      check_dump("en.redump");

      // Reset mid-dump: outputs and sticky flags clear at once.
      for (int n = 0; n < HP; n++) pulse(6'($urandom));
      model_strobe(1'b1, 4'd4);
      fork
         strobe(4'd4);
         begin
            wait_col(30, f);
            chk("rstm.reach30", int'(f), 1);
            rst_n = 1'b0;
            i_enable = 1'b0;
            #1;
            chk("rstm.valid",   o_wr_valid, 0);
            chk("rstm.addr",    o_wr_addr, 0);
            chk("rstm.err_cnt", o_err_count, 0);
            chk("rstm.err_ovr", o_err_overrun, 0);
         end
      join
      step(3);
      rst_n = 1'b1;
      model_reset();
      rd_ptr = got_n;
      step(6);
      i_enable = 1'b1;
      step(2);
      for (int n = 0; n < HP; n++) pulse(6'($urandom));
      model_strobe(1'b1, 4'd10);
      strobe(4'd10);
      check_dump("rstm.redump");
      chk("rstm.err_after", o_err_count, 0);

      // O_CLK rise and STB rise together: 63 + the simultaneous one = 64.
      for (int n = 0; n < HP - 1; n++) pulse(6'($urandom));
      O_CLK = 1'b0;
      {R1, G1, B1, R2, G2, B2} = 6'h2a;
      {D, C, B, A} = 4'd13;
      step(2);
      O_CLK = 1'b1;
      STB = 1'b1;
      model_push(6'h2a);
      model_strobe(1'b1, 4'd13);
      step(2);
      O_CLK = 1'b0;
      STB = 1'b0;
      step(2);
      check_dump("sim");
      chk("sim.err_cnt", o_err_count, 0);

      // Randomized rows with random backpressure against the model.
      rand_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         int r, np;
         logic [3:0] row;
         r = int'($urandom_range(0, 5));
         np = (r == 0) ? HP - 1 : (r == 1) ? HP + 1 : HP;
         row = 4'($urandom);
         for (int n = 0; n < np; n++) pulse(6'($urandom));
         model_strobe(1'b1, row);
         strobe(row);
         check_dump($sformatf("rnd%0d", k));
         chk($sformatf("rnd%0d.err_cnt", k), o_err_count, int'(m_err));
      end
      rand_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hub75_rx_monitor.md
Name: hub75_rx_monitor

Overview:
- Receive-side counterpart of the HUB75 display driver: samples a HUB75 output bus (O_CLK, STB, OE, A-D, R1/G1/B1/R2/G2/B2) in the system clock domain.
- Rebuilds each latched row's shift-register contents and streams them out as column words over a valid/ready write interface.
- Measures the OE-active time of each latched row and flags protocol errors.
- Used as a loopback checker / panel model in FPGA self-test and in simulation benches.

Parameters:
- hpixel_p, 64, panel width in pixels (shift-chain length per row)
- oe_cnt_width_p, 16, width of the OE-low duration counter
- sync_stages_p, 2, synchroniser depth on all HUB75 inputs (minimum 2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_enable  input  1  monitor enable
- O_CLK  input  1  HUB75 shift clock; shift on rising edge
- STB  input  1  HUB75 latch strobe; latch on rising edge
- OE  input  1  HUB75 output enable, active low
- A, B, C, D  input  1 each  row select, A = LSB
- R1, G1, B1, R2, G2, B2  input  1 each  upper/lower segment colour bits
- o_wr_valid  output  1  column word valid
- i_wr_ready  input  1  sink accepts word
- o_wr_addr  output  4+$clog2(hpixel_p)  {row[3:0], col}
- o_wr_data  output  6  {R1,G1,B1,R2,G2,B2} for that column
- o_wr_last  output  1  high with column hpixel_p-1
- o_oe_valid  output  1  one-cycle pulse: OE duration result ready
- o_oe_row  output  4  row the OE result belongs to
- o_oe_cycles  output  oe_cnt_width_p  clk cycles OE was low, saturating
- o_err_count  output  1  sticky: STB seen after a shift count other than hpixel_p
- o_err_overrun  output  1  sticky: STB while dump busy, latch dropped

Behaviour:
- Reset: every output is 0; all synchroniser flops are 0; FSM is IDLE; counters and shift/latch registers are 0. Sticky errors clear only on reset.
- Synchronisers:
  - All 13 HUB75 inputs pass through sync_stages_p flops.
  - Edges are detected by comparing the last stage with one extra register.
  - Data is taken from the same stage as the O_CLK edge.
  - O_CLK high and low phases must each be at least 2 clk periods; narrower pulses are unsupported.
  - Input-to-detect latency is sync_stages_p+1 cycles.
- Shift path:
  - On each detected O_CLK rise, the 6-bit data word shifts into column 0 and existing columns move to index+1; column hpixel_p-1 is discarded.
  - shift_cnt increments and saturates at hpixel_p+1.
- Latch, on detected STB rise:
  - If shift_cnt != hpixel_p, set o_err_count.
  - If FSM is IDLE: copy the shift register into the latch register, capture {D,C,B,A} as the latched row, and go to DUMP.
  - If FSM is DUMP: drop the latch and set o_err_overrun.
  - In all cases shift_cnt resets to 0.
  - The shift register itself is not cleared.
- Simultaneous O_CLK rise and STB rise in the same cycle: the shift is applied first. The latched row includes the new column; the count check uses the incremented count.
- Dump FSM:
  - IDLE: o_wr_valid=0.
  - DUMP:
    - o_wr_valid=1, col starts at 0.
    - o_wr_addr={row,col}, o_wr_data=latch[col], o_wr_last=(col==hpixel_p-1).
    - Outputs are held stable while i_wr_ready=0.
    - When o_wr_valid and i_wr_ready are both high, col increments.
    - On the transfer with o_wr_last=1, return to IDLE.
  - Minimum dump time is hpixel_p cycles. First valid appears the cycle after the STB detect.
- OE measurement:
  - The OE counter resets to 0 on each STB detect.
  - It increments every cycle the synchronised OE is 0 and saturates at all-ones.
  - On a detected OE rise (0→1) with a nonzero count: pulse o_oe_valid for 1 cycle, present o_oe_cycles = count, and present o_oe_row = last latched row, or the dropped row's address on overrun.
  - The counter then clears.
- i_enable=0:
  - Synchronisers keep running.
  - Shift, OE and column counters are held at 0, and the FSM is forced to IDLE; an in-progress dump is aborted and o_wr_valid goes low the next cycle.
  - STB and O_CLK edges are ignored, and sticky flags are held.
  - On re-enable, capture resumes at the next edge.
- Reset asserted mid-operation: all state and outputs clear asynchronously; no partial dump completes.

Test Plan:
- Send 64 O_CLK pulses where pulse n carries data n[5:0], then STB with row=5. Required: 64 words, addr {5,0}..{5,63}, and word col c has data = (63-c)[5:0]. o_wr_last is set on col 63 only. No errors.
- Repeat the above while holding i_wr_ready=0 for 10 cycles at col 17. Required: addr and data hold steady at col 17, no words are lost, 64 words total.
- Send 63 pulses, then STB. Required: o_err_count=1 and the dump still emits 64 words. Send 65 pulses then STB: flag remains set.
- Issue a second STB 20 cycles after the first while the dump is active. Required: o_err_overrun=1, and the first row's 64 words are unchanged.
- Latch row 9, then hold OE low for 300 cycles. Required: one o_oe_valid pulse with o_oe_cycles=300 and o_oe_row=9. With oe_cnt_width_p=8 and 300 cycles low, required o_oe_cycles=255.
- Deassert i_enable at col 30, or assert rst_n low mid-dump. Required: o_wr_valid=0 the next cycle (immediately for reset); after re-enable, the next full row dumps correctly starting at col 0.
